// File: rtl/reg_operand_mux_pkg.sv
// Shared types and defaults for the register operand mux and its skid store.
package reg_operand_mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_NREGS = 16;

endpackage

// File: rtl/operand_skid.sv
// Two-entry skid store: registered head feeds the output, tail absorbs one extra
// result so in_ready can be a flop rather than a combinational path from out_ready.
module operand_skid
    import reg_operand_mux_pkg::*;
#(
    parameter int PW = 33
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    skid_state_t   state;
    skid_state_t   state_next;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          accept;
    logic          consume;
    logic          load_head_in;
    logic          load_head_tail;
    logic          load_tail;

    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign out_valid = (state != EMPTY);
    assign out_data  = head;

    // in_ready stays low through reset and rises on the first edge afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != FULL);
        end
    end

    always_comb begin
        state_next     = state;
        load_head_in   = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_head_in = 1'b1;
                    state_next   = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    load_tail  = 1'b1;
                    state_next = FULL;
                end else if (consume) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    load_head_tail = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head_in) begin
                head <= in_data;
            end else if (load_head_tail) begin
                head <= tail;
            end
            if (load_tail) begin
                tail <= in_data;
            end
        end
    end

endmodule

// File: rtl/reg_operand_mux.sv
// Operand select with immediate override and range check, buffered by operand_skid.
// Define REG_OPERAND_MUX_FWD_EN to forward same-cycle writeback data into the operands.
module reg_operand_mux
    import reg_operand_mux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int NREGS = DEFAULT_NREGS,
    localparam int SELW  = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREGS*WIDTH-1:0] regs_flat,
    input  logic [SELW-1:0]        sel_a,
    input  logic [SELW-1:0]        sel_b,
    input  logic                   imm_mode,
    input  logic [WIDTH-1:0]       imm,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   wb_en,
    input  logic [SELW-1:0]        wb_addr,
    input  logic [WIDTH-1:0]       wb_data,
    output logic [WIDTH-1:0]       op_a,
    output logic [WIDTH-1:0]       op_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sel_err
);

    localparam int PW = 2 * WIDTH + 1;

    logic [WIDTH-1:0] reg_arr [NREGS];
    logic             a_bad;
    logic             b_bad;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;
    logic             err;
    logic [PW-1:0]    payload;
    logic [PW-1:0]    result;

    for (genvar i = 0; i < NREGS; i++) begin : g_unpack
        assign reg_arr[i] = regs_flat[i*WIDTH +: WIDTH];
    end

    assign a_bad = 32'(sel_a) >= 32'(NREGS);
    assign b_bad = 32'(sel_b) >= 32'(NREGS);

    // An out-of-range select wins over forwarding: the operand is forced to zero.
    always_comb begin
        a_val = a_bad ? '0 : reg_arr[sel_a];
        b_val = imm_mode ? imm : (b_bad ? '0 : reg_arr[sel_b]);
`ifdef REG_OPERAND_MUX_FWD_EN
        if (wb_en && !a_bad && (wb_addr == sel_a)) begin
            a_val = wb_data;
        end
        if (wb_en && !imm_mode && !b_bad && (wb_addr == sel_b)) begin
            b_val = wb_data;
        end
`endif
        err = a_bad || (!imm_mode && b_bad);
    end

`ifndef REG_OPERAND_MUX_FWD_EN
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_addr, wb_data};
`endif

    assign payload = {err, a_val, b_val};

    operand_skid #(
        .PW(PW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (result)
    );

    assign sel_err = result[PW-1];
    assign op_a    = result[2*WIDTH-1:WIDTH];
    assign op_b    = result[WIDTH-1:0];

endmodule

// File: tb/tb_reg_operand_mux.sv
// Directed bench for reg_operand_mux (WIDTH=16, NREGS=12): vector table plus stall/reset sequences.
module tb_reg_operand_mux;

    localparam int WIDTH = 16;
    localparam int NREGS = 12;
    localparam int SELW  = 4;
`ifdef REG_OPERAND_MUX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [SELW-1:0]  sel_a;
        logic [SELW-1:0]  sel_b;
        logic             imm_mode;
        logic [WIDTH-1:0] imm;
        logic             wb_en;
        logic [SELW-1:0]  wb_addr;
        logic [WIDTH-1:0] wb_data;
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;
        logic             exp_err;
    } vec_t;

    logic                   clk;
    logic                   reset;
    logic [NREGS*WIDTH-1:0] regs_flat;
    logic [SELW-1:0]        sel_a;
    logic [SELW-1:0]        sel_b;
    logic                   imm_mode;
    logic [WIDTH-1:0]       imm;
    logic                   in_valid;
    logic                   in_ready;
    logic                   wb_en;
    logic [SELW-1:0]        wb_addr;
    logic [WIDTH-1:0]       wb_data;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sel_err;

    int checks;
    int passes;

    vec_t vecs [9];

    reg_operand_mux #(
        .WIDTH(WIDTH),
        .NREGS(NREGS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .regs_flat(regs_flat),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .imm_mode (imm_mode),
        .imm      (imm),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .op_a     (op_a),
        .op_b     (op_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic err);
        checkValue({tag, " out_valid"}, 32'(out_valid), 32'd1);
        checkValue({tag, " op_a"}, 32'(op_a), 32'(a));
        checkValue({tag, " op_b"}, 32'(op_b), 32'(b));
        checkValue({tag, " sel_err"}, 32'(sel_err), 32'(err));
    endtask

    task automatic setRequest(input logic [SELW-1:0] a, input logic [SELW-1:0] b);
        sel_a    = a;
        sel_b    = b;
        imm_mode = 1'b0;
        imm      = '0;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        in_valid = 1'b1;
    endtask

    // One request with out_ready high; result is checked one cycle after acceptance.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        checkValue($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'd1);
        sel_a    = v.sel_a;
        sel_b    = v.sel_b;
        imm_mode = v.imm_mode;
        imm      = v.imm;
        wb_en    = v.wb_en;
        wb_addr  = v.wb_addr;
        wb_data  = v.wb_data;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wb_en    = 1'b0;
        checkOutput($sformatf("vec%0d", idx), v.exp_a, v.exp_b, v.exp_err);
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel_a     = '0;
        sel_b     = '0;
        imm_mode  = 1'b0;
        imm       = '0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_flat[i*WIDTH +: WIDTH] = 16'(16'h0101 * i);
        end
        regs_flat[3*WIDTH +: WIDTH] = 16'h1234;
        regs_flat[5*WIDTH +: WIDTH] = 16'hABCD;

        vecs[0] = '{4'd3,  4'd5,  1'b0, 16'h0000, 1'b0, 4'd0,  16'h0000, 16'h1234, 16'hABCD, 1'b0};
        vecs[1] = '{4'd7,  4'd12, 1'b1, 16'h00FF, 1'b0, 4'd0,  16'h0000, 16'h0707, 16'h00FF, 1'b0};
        vecs[2] = '{4'd7,  4'd12, 1'b0, 16'h00FF, 1'b0, 4'd0,  16'h0000, 16'h0707, 16'h0000, 1'b1};
        vecs[3] = '{4'd13, 4'd11, 1'b0, 16'h0000, 1'b0, 4'd0,  16'h0000, 16'h0000, 16'h0B0B, 1'b1};
        vecs[4] = '{4'd3,  4'd3,  1'b0, 16'h0000, 1'b1, 4'd3,  16'h5555,
                    FWD ? 16'h5555 : 16'h1234, FWD ? 16'h5555 : 16'h1234, 1'b0};
        vecs[5] = '{4'd3,  4'd5,  1'b1, 16'hBEEF, 1'b1, 4'd3,  16'h5555,
                    FWD ? 16'h5555 : 16'h1234, 16'hBEEF, 1'b0};
        vecs[6] = '{4'd3,  4'd3,  1'b0, 16'h0000, 1'b0, 4'd3,  16'h5555, 16'h1234, 16'h1234, 1'b0};
        vecs[7] = '{4'd0,  4'd11, 1'b0, 16'h0000, 1'b0, 4'd0,  16'h0000, 16'h0000, 16'h0B0B, 1'b0};
        vecs[8] = '{4'd0,  4'd11, 1'b0, 16'h0000, 1'b1, 4'd11, 16'h7777,
                    16'h0000, FWD ? 16'h7777 : 16'h0B0B, 1'b0};

        // Reset state and release timing.
        repeat (2) @(negedge clk);
        checkValue("reset out_valid", 32'(out_valid), 32'd0);
        checkValue("reset in_ready", 32'(in_ready), 32'd0);
        checkValue("reset op_a", 32'(op_a), 32'd0);
        checkValue("reset op_b", 32'(op_b), 32'd0);
        checkValue("reset sel_err", 32'(sel_err), 32'd0);
        reset = 1'b0;
        #1;
        checkValue("release in_ready before edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkValue("release in_ready after edge", 32'(in_ready), 32'd1);
        checkValue("release out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], i);
        end
        @(negedge clk);
        checkValue("drain out_valid", 32'(out_valid), 32'd0);

        // Stall: R1, R2 fill the store, R3 is held off until space opens.
        out_ready = 1'b0;
        setRequest(4'd1, 4'd2);
        @(negedge clk);
        checkOutput("stall R1", 16'h0101, 16'h0202, 1'b0);
        checkValue("stall in_ready after R1", 32'(in_ready), 32'd1);
        setRequest(4'd4, 4'd6);
        @(negedge clk);
        checkValue("stall in_ready after R2", 32'(in_ready), 32'd0);
        checkOutput("stall hold1", 16'h0101, 16'h0202, 1'b0);
        setRequest(4'd8, 4'd9);
        @(negedge clk);
        checkValue("stall in_ready full", 32'(in_ready), 32'd0);
        checkOutput("stall hold2", 16'h0101, 16'h0202, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("order R2", 16'h0404, 16'h0606, 1'b0);
        checkValue("order in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("order R3", 16'h0808, 16'h0909, 1'b0);
        @(negedge clk);
        checkValue("order drained", 32'(out_valid), 32'd0);

        // Reset mid-cycle while FULL.
        out_ready = 1'b0;
        setRequest(4'd10, 4'd11);
        @(negedge clk);
        setRequest(4'd2, 4'd3);
        @(negedge clk);
        in_valid = 1'b0;
        checkValue("prefull in_ready", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkValue("midreset out_valid", 32'(out_valid), 32'd0);
        checkValue("midreset in_ready", 32'(in_ready), 32'd0);
        checkValue("midreset op_a", 32'(op_a), 32'd0);
        checkValue("midreset sel_err", 32'(sel_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        checkValue("rerelease in_ready before edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkValue("rerelease in_ready", 32'(in_ready), 32'd1);
        checkValue("rerelease no stale", 32'(out_valid), 32'd0);
        applyStimulus(vecs[0], 9);
        @(negedge clk);
        checkValue("final drain", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
